enable_sequence_checker: RTL and testbench
==========================================

# enable_sequence_checker

Receive-side checker for the 10-phase one-hot enable sequence produced by the enable controller. It samples the enable vector every clock, decodes it back to a phase index, and verifies strict one-hot encoding and in-order wrap-around (0,1,…,N_EN-1,0,…). It declares lock after a programmable number of clean periods and counts sequence errors. It sits beside the datapath consuming the enables and feeds status and debug logic.

## Interface
- N_EN, default 10: number of enable phases (2..16).
- LOCK_PERIODS, default 2: consecutive clean full periods required to assert lock (1..15).
- ERR_W, default 8: width of the saturating error counter.

- clk_i, input, 1: clock; all logic on rising edge.
- reset_ni, input, 1: reset, asynchronous, active-low.
- enable_i, input, N_EN: enable vector; bit k is phase k (bit 0 = enable1 … bit 9 = enable10).
- clear_i, input, 1: synchronous clear of err_count_o and err_sticky_o.
- phase_o, output, 4: decoded phase index of the previous-cycle sample.
- phase_valid_o, output, 1: phase_o holds an accepted in-sequence phase.
- period_done_o, output, 1: one-cycle pulse after phase N_EN-1 accepted.
- locked_o, output, 1: sequence locked.
- err_o, output, 1: one-cycle pulse per detected error.
- err_sticky_o, output, 1: set on any error, held until clear_i or reset.
- err_count_o, output, ERR_W: saturating error count.

## Operation
- Per-cycle classification of enable_i: ZERO (no bits), ONEHOT(k), MULTI (≥2 bits).
- State machine, states SEARCH, TRACK, LOCKED; internal expected index exp (4 bits), clean-period counter good (4 bits).
- SEARCH: ONEHOT(0) -> TRACK, exp=1, good=0, accepted. ZERO or ONEHOT(k≠0) -> stay, no error. MULTI -> stay, error.
- TRACK: ONEHOT(exp) -> accepted; exp = (exp==N_EN-1) ? 0 : exp+1. On accepting N_EN-1: good+1; if good+1 == LOCK_PERIODS -> LOCKED. Any other input (ZERO, MULTI, wrong index) -> error, SEARCH, good=0.
- LOCKED: same acceptance/advance rule as TRACK; any mismatch -> error, SEARCH, locked_o drops.
- A mismatch in TRACK/LOCKED that is ONEHOT(0) still returns to SEARCH; it is not re-accepted as a period start in the same cycle.
- err_count_o: +1 per error, saturates at 2^ERR_W-1, never wraps.
- clear_i wins over a simultaneous error: err_count_o=0, err_sticky_o=0, err_o still pulses.
- clear_i has no effect on state, lock, or phase outputs.

## Timing
- All outputs registered; one-cycle latency from enable_i sample to phase_o/phase_valid_o/err_o/period_done_o.
- locked_o rises in the same cycle as the period_done_o pulse that completes the LOCK_PERIODS-th clean period; falls in the same cycle as the err_o pulse that breaks the sequence.
- phase_valid_o=0 and phase_o holds its last value on cycles following a non-accepted sample.
- Reset (reset_ni low, any time, including mid-period or while locked): state=SEARCH, exp=0, good=0, phase_o=0, phase_valid_o=0, period_done_o=0, locked_o=0, err_o=0, err_sticky_o=0, err_count_o=0. No pending pulse survives reset.
- Back-to-back errors each pulse err_o and each increment the counter.
- Wrap-around: after accepting N_EN-1, only ONEHOT(0) is accepted on the next cycle.

## Test plan
- Release reset, drive ZERO for 3 cycles, then clean sequence 0..9 repeating from cycle 3 -> no errors. phase_o follows the sample by 1 cycle. period_done_o pulses after samples at cycles 12 and 22. locked_o=1 from the cycle after the sample at cycle 22.
- While locked, replace phase 5 with phase 6 -> err_o pulses once, err_count_o=1, locked_o=0, phase_valid_o=0. The sequence resumes at the next phase 0; relock follows after 2 clean periods.
- Drive 0x003 (two bits) in SEARCH, then ZERO in LOCKED -> two err_o pulses, err_count_o=2, err_sticky_o=1.
- With ERR_W=2, inject 5 errors -> err_count_o stops at 3.
- Inject an error in the same cycle clear_i=1 -> err_o pulses, err_count_o=0, err_sticky_o=0.
- Assert reset_ni low mid-period while locked -> all outputs 0 immediately. After release, ONEHOT(4) is ignored without error; lock requires a new phase-0 start.

Source files
------------

// File: rtl/enable_sequence_checker_if.sv
// Signal bundle between the enable-consuming datapath and the sequence checker.
// The master side drives enables and clear; the slave (the checker) returns status.
interface enable_sequence_checker_if #(
  parameter int N_EN  = 10,
  parameter int ERR_W = 8
);
  logic [N_EN-1:0]  enable_i;
  logic             clear_i;
  logic [3:0]       phase_o;
  logic             phase_valid_o;
  logic             period_done_o;
  logic             locked_o;
  logic             err_o;
  logic             err_sticky_o;
  logic [ERR_W-1:0] err_count_o;

  modport master (
    output enable_i, clear_i,
    input  phase_o, phase_valid_o, period_done_o, locked_o,
           err_o, err_sticky_o, err_count_o
  );

  modport slave (
    input  enable_i, clear_i,
    output phase_o, phase_valid_o, period_done_o, locked_o,
           err_o, err_sticky_o, err_count_o
  );
endinterface

// File: rtl/enable_sequence_checker.sv
// Receive-side checker for a one-hot N_EN-phase enable sequence: decodes the phase,
// verifies strict in-order wrap-around, declares lock and counts errors.
module enable_sequence_checker #(
  parameter int N_EN         = 10,
  parameter int LOCK_PERIODS = 2,
  parameter int ERR_W        = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  enable_sequence_checker_if.slave     bus
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t     state;
  logic [3:0] exp;
  logic [3:0] good;

  logic       zero, onehot, multi;
  logic [3:0] idx;
  logic       accept, error, last;

  always_comb begin
    idx = '0;
    for (int k = 0; k < N_EN; k++)
      if (bus.enable_i[k]) idx = 4'(k);
  end

  assign zero   = (bus.enable_i == '0);
  assign onehot = !zero && ((bus.enable_i & (bus.enable_i - 1'b1)) == '0);
  assign multi  = !zero && !onehot;

  // exp is held at 0 while searching, so a phase-0 hit doubles as the start condition.
  assign accept = onehot && (idx == exp);
  assign error  = (state == SEARCH) ? multi : !accept;
  assign last   = (exp == 4'(N_EN - 1));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state             <= SEARCH;
      exp               <= '0;
      good              <= '0;
      bus.phase_o       <= '0;
      bus.phase_valid_o <= 1'b0;
      bus.period_done_o <= 1'b0;
      bus.locked_o      <= 1'b0;
      bus.err_o         <= 1'b0;
      bus.err_sticky_o  <= 1'b0;
      bus.err_count_o   <= '0;
    end else begin
      bus.phase_valid_o <= accept;
      bus.period_done_o <= accept && last;
      bus.err_o         <= error;
      if (accept) bus.phase_o <= idx;

      if (bus.clear_i) begin
        bus.err_count_o  <= '0;
        bus.err_sticky_o <= 1'b0;
      end else if (error) begin
        bus.err_sticky_o <= 1'b1;
        if (bus.err_count_o != '1) bus.err_count_o <= bus.err_count_o + 1'b1;
      end

      if (error && state != SEARCH) begin
        state        <= SEARCH;
        exp          <= '0;
        good         <= '0;
        bus.locked_o <= 1'b0;
      end else if (accept) begin
        exp <= last ? 4'd0 : exp + 4'd1;
        if (state == SEARCH) begin
          state <= TRACK;
          good  <= '0;
        end else if (last && state == TRACK) begin
          good <= good + 4'd1;
          if (good + 4'd1 == 4'(LOCK_PERIODS)) begin
            state        <= LOCKED;
            bus.locked_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_enable_sequence_checker.sv
// Directed bench: a phase-level reference model checked every cycle, plus literal
// expectations at the interesting points of each scenario.
module tb_enable_sequence_checker;
  localparam int N    = 10;
  localparam int LOCK = 2;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk = ~clk;

  enable_sequence_checker_if #(.N_EN(N), .ERR_W(8)) u_if ();
  enable_sequence_checker_if #(.N_EN(N), .ERR_W(2)) u_if2 ();
  assign u_if2.enable_i = u_if.enable_i;
  assign u_if2.clear_i  = u_if.clear_i;

  enable_sequence_checker #(.N_EN(N), .LOCK_PERIODS(LOCK), .ERR_W(8)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .bus(u_if.slave));
  enable_sequence_checker #(.N_EN(N), .LOCK_PERIODS(LOCK), .ERR_W(2)) dut2 (
    .clk_i(clk), .reset_ni(reset_ni), .bus(u_if2.slave));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, want);
    end
  endtask

  // Reference model: synced flag, next phase expected, clean periods seen.
  bit synced = 0;
  int nxt = 0, periods = 0;
  int m_phase = 0, m_cnt = 0, m_cnt2 = 0;
  bit m_pv = 0, m_pd = 0, m_err = 0, m_sticky = 0;

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      synced = 0; nxt = 0; periods = 0;
      m_phase = 0; m_pv = 0; m_pd = 0; m_err = 0; m_sticky = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      int ones, pos;
      bit acc;
      ones = $countones(u_if.enable_i);
      pos = -1;
      for (int k = 0; k < N; k++) if (u_if.enable_i[k]) pos = k;
      acc = (ones == 1) && (pos == (synced ? nxt : 0));
      m_err = synced ? !acc : (ones >= 2);
      m_pv = acc;
      m_pd = acc && synced && pos == N - 1;
      if (acc) begin
        m_phase = pos;
        if (synced && pos == N - 1) periods++;
        if (!synced) periods = 0;
        synced = 1;
        nxt = (pos + 1) % N;
      end else if (m_err && synced) begin
        synced = 0; nxt = 0; periods = 0;
      end
      if (u_if.clear_i) begin
        m_cnt = 0; m_cnt2 = 0; m_sticky = 0;
      end else if (m_err) begin
        m_sticky = 1;
        m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
      end
    end
  end

  always @(negedge clk) begin
    chk("phase",  int'(u_if.phase_o),       m_phase);
    chk("pvalid", int'(u_if.phase_valid_o), int'(m_pv));
    chk("pdone",  int'(u_if.period_done_o), int'(m_pd));
    chk("locked", int'(u_if.locked_o),      int'(synced && periods >= LOCK));
    chk("err",    int'(u_if.err_o),         int'(m_err));
    chk("sticky", int'(u_if.err_sticky_o),  int'(m_sticky));
    chk("count",  int'(u_if.err_count_o),   m_cnt);
    chk("count2", int'(u_if2.err_count_o),  m_cnt2);
    chk("locked2", int'(u_if2.locked_o),    int'(u_if.locked_o));
  end

  task automatic step(input logic [N-1:0] en, input logic clr = 1'b0);
    u_if.enable_i = en;
    u_if.clear_i  = clr;
    @(negedge clk);
  endtask

  task automatic period();
    for (int p = 0; p < N; p++) step(N'(1) << p);
  endtask

  task automatic do_reset();
    u_if.enable_i = '0;
    u_if.clear_i  = 1'b0;
    #2 reset_ni = 1'b0;
    #1;
    chk("rst_phase",  int'(u_if.phase_o), 0);
    chk("rst_pvalid", int'(u_if.phase_valid_o), 0);
    chk("rst_pdone",  int'(u_if.period_done_o), 0);
    chk("rst_locked", int'(u_if.locked_o), 0);
    chk("rst_err",    int'(u_if.err_o), 0);
    chk("rst_sticky", int'(u_if.err_sticky_o), 0);
    chk("rst_count",  int'(u_if.err_count_o), 0);
    #1 reset_ni = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    u_if.enable_i = '0;
    u_if.clear_i  = 1'b0;
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;

    // Clean lock-up after three idle cycles
    repeat (3) step('0);
    step(N'(1));
    chk("l_first_phase", int'(u_if.phase_o), 0);
    chk("l_first_pv", int'(u_if.phase_valid_o), 1);
    for (int p = 1; p < N; p++) step(N'(1) << p);
    chk("l_pd1", int'(u_if.period_done_o), 1);
    chk("l_nolock1", int'(u_if.locked_o), 0);
    period();
    chk("l_pd2", int'(u_if.period_done_o), 1);
    chk("l_lock2", int'(u_if.locked_o), 1);

    // Phase 5 replaced by phase 6 while locked
    for (int p = 0; p < 5; p++) step(N'(1) << p);
    step(N'(1) << 6);
    chk("s_err", int'(u_if.err_o), 1);
    chk("s_cnt", int'(u_if.err_count_o), 1);
    chk("s_unlock", int'(u_if.locked_o), 0);
    chk("s_pv", int'(u_if.phase_valid_o), 0);
    chk("s_phase_hold", int'(u_if.phase_o), 4);
    for (int p = 7; p < N; p++) step(N'(1) << p);
    chk("s_search_quiet", int'(u_if.err_o), 0);
    period();
    period();
    chk("s_relock", int'(u_if.locked_o), 1);

    // Multi-bit in SEARCH, then ZERO while locked
    do_reset();
    step(N'(3));
    chk("m_err", int'(u_if.err_o), 1);
    chk("m_cnt", int'(u_if.err_count_o), 1);
    period();
    period();
    step('0);
    chk("z_err", int'(u_if.err_o), 1);
    chk("z_cnt", int'(u_if.err_count_o), 2);
    chk("z_sticky", int'(u_if.err_sticky_o), 1);

    // Back-to-back errors; narrow counter saturates
    repeat (5) step(N'(3));
    chk("b_cnt", int'(u_if.err_count_o), 7);
    chk("b_sat", int'(u_if2.err_count_o), 3);

    // Clear beats a simultaneous error
    step(N'(3), 1'b1);
    chk("c_err", int'(u_if.err_o), 1);
    chk("c_cnt", int'(u_if.err_count_o), 0);
    chk("c_sticky", int'(u_if.err_sticky_o), 0);
    step(N'(3));
    step('0, 1'b1);
    chk("c2_cnt", int'(u_if.err_count_o), 0);

    // Reset mid-period while locked
    step(N'(3));
    period();
    period();
    for (int p = 0; p < 4; p++) step(N'(1) << p);
    chk("r_prelock", int'(u_if.locked_o), 1);
    do_reset();
    step(N'(1) << 4);
    chk("r_ignore_err", int'(u_if.err_o), 0);
    chk("r_ignore_pv", int'(u_if.phase_valid_o), 0);
    period();
    chk("r_pd", int'(u_if.period_done_o), 1);
    chk("r_nolock", int'(u_if.locked_o), 0);

    // Only phase 0 follows the last phase
    step(N'(1) << 1);
    chk("w_err", int'(u_if.err_o), 1);
    step('0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
